// File: rtl/tdm_selector41_pkg.sv
// Shared types and constants for the tdm_selector41 four-channel TDM collector.
package tdm_selector41_pkg;

    localparam int CH_W = 2;
    localparam int N_CH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic par_acc(input logic acc, input logic sample);
        return acc ^ sample;
    endfunction

endpackage

// File: rtl/tdm_next_chan.sv
// Cyclic priority search: next enabled channel above chan_i, plus a flag telling
// whether that channel is the lowest enabled one (i.e. it starts a frame).
module tdm_next_chan
    import tdm_selector41_pkg::*;
(
    input  logic [CH_W-1:0] chan_i,
    input  logic [N_CH-1:0] mask_i,
    output logic [CH_W-1:0] next_o,
    output logic            is_first_o
);

    logic [CH_W-1:0] idx_s;
    logic [CH_W-1:0] low_s;
    logic            found_s;
    logic            low_found_s;
    logic            hit_s;

    // Scan upward from chan_i+1 with wrap; the fourth step revisits chan_i itself.
    always_comb begin
        next_o      = chan_i;
        idx_s       = chan_i;
        found_s     = 1'b0;
        hit_s       = 1'b0;
        low_s       = {CH_W{1'b0}};
        low_found_s = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx_s   = chan_i + CH_W'(i);
            hit_s   = !found_s && mask_i[idx_s];
            next_o  = hit_s ? idx_s : next_o;
            found_s = found_s | hit_s;
        end
        for (int k = 0; k < N_CH; k++) begin
            hit_s       = !low_found_s && mask_i[k];
            low_s       = hit_s ? CH_W'(k) : low_s;
            low_found_s = low_found_s | hit_s;
        end
        is_first_o = found_s && (next_o == low_s);
    end

endmodule

// File: rtl/tdm_selector41.sv
// Four-to-one TDM selector: round-robin over enabled channels, SLOT_CYCLES per slot.
// Optional frame parity output enabled by defining TDM_SELECTOR41_PARITY_EN.
module tdm_selector41
    import tdm_selector41_pkg::*;
#(
    parameter int SLOT_CYCLES = 4
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEn,
    input  logic       iC0,
    input  logic       iC1,
    input  logic       iC2,
    input  logic       iC3,
    input  logic [3:0] iMask,
    output logic       oZ,
    output logic       oS1,
    output logic       oS0,
    output logic       oValid,
    output logic       oFrame
`ifdef TDM_SELECTOR41_PARITY_EN
    ,
    output logic       oParity
`endif
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CH_W-1:0] chan_q, chan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            z_q, z_d;
    logic            valid_q, valid_d;
    logic            frame_q, frame_d;
    logic            acc_q, acc_d;
    logic            par_q, par_d;

    logic [N_CH-1:0] lines_s;
    logic [CH_W-1:0] search_from_s;
    logic [CH_W-1:0] next_chan_s;
    logic            first_s;
    logic            go_s;
    logic            sample_s;

    assign lines_s  = {iC3, iC2, iC1, iC0};
    assign go_s     = iEn && (iMask != 4'b0000);
    // From IDLE, searching above the top channel yields the lowest enabled one.
    assign search_from_s = (state_q == RUN) ? chan_q : CH_W'(N_CH - 1);
    assign sample_s = lines_s[next_chan_s];

    tdm_next_chan u_next (
        .chan_i     (search_from_s),
        .mask_i     (iMask),
        .next_o     (next_chan_s),
        .is_first_o (first_s)
    );

    // Next-state and output-register logic for the IDLE/RUN scanner.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        valid_d = valid_q;
        frame_d = 1'b0;
        acc_d   = acc_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (go_s) begin
                    state_d = RUN;
                    chan_d  = next_chan_s;
                    cnt_d   = {CNT_W{1'b0}};
                    z_d     = sample_s;
                    valid_d = 1'b1;
                    frame_d = 1'b1;
                    acc_d   = sample_s;
                    par_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                    chan_d  = {CH_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    z_d     = 1'b0;
                    valid_d = 1'b0;
                    acc_d   = 1'b0;
                    par_d   = 1'b0;
                end
            end
            RUN: begin
                if (!go_s) begin
                    state_d = IDLE;
                    chan_d  = {CH_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    z_d     = 1'b0;
                    valid_d = 1'b0;
                    acc_d   = 1'b0;
                    par_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    chan_d  = next_chan_s;
                    z_d     = sample_s;
                    frame_d = first_s;
                    // A frame-start boundary publishes the finished frame and restarts the fold.
                    if (first_s) begin
                        par_d = acc_q;
                        acc_d = sample_s;
                    end else begin
                        acc_d = par_acc(acc_q, sample_s);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                chan_d  = {CH_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                z_d     = 1'b0;
                valid_d = 1'b0;
                acc_d   = 1'b0;
                par_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            chan_q  <= {CH_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            z_q     <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            acc_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            acc_q   <= acc_d;
            par_q   <= par_d;
        end
    end

    assign oZ     = z_q;
    assign oS1    = chan_q[1];
    assign oS0    = chan_q[0];
    assign oValid = valid_q;
    assign oFrame = frame_q;

`ifdef TDM_SELECTOR41_PARITY_EN
    assign oParity = par_q;
`else
    logic unused_par_s;
    assign unused_par_s = par_q ^ acc_q;
`endif

endmodule

// File: tb/tb_tdm_selector41.sv
// Self-checking bench for tdm_selector41 (SLOT_CYCLES=2 main instance, SLOT_CYCLES=1 aux).
module tb_tdm_selector41;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] mask;
    logic [3:0] c;

    logic z2, s1_2, s0_2, v2, f2;
    logic z1, s1_1, s0_1, v1, f1;
`ifdef TDM_SELECTOR41_PARITY_EN
    logic par2, par1;
`endif

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic [3:0] c;
        logic [4:0] exp;   // {valid, frame, s1, s0, z}
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    tdm_selector41 #(.SLOT_CYCLES(2)) dut2 (
        .iClk(clk), .iRst_n(rst_n), .iEn(en),
        .iC0(c[0]), .iC1(c[1]), .iC2(c[2]), .iC3(c[3]), .iMask(mask),
        .oZ(z2), .oS1(s1_2), .oS0(s0_2), .oValid(v2), .oFrame(f2)
`ifdef TDM_SELECTOR41_PARITY_EN
        , .oParity(par2)
`endif
    );

    tdm_selector41 #(.SLOT_CYCLES(1)) dut1 (
        .iClk(clk), .iRst_n(rst_n), .iEn(en),
        .iC0(c[0]), .iC1(c[1]), .iC2(c[2]), .iC3(c[3]), .iMask(mask),
        .oZ(z1), .oS1(s1_1), .oS0(s0_1), .oValid(v1), .oFrame(f1)
`ifdef TDM_SELECTOR41_PARITY_EN
        , .oParity(par1)
`endif
    );

    function automatic logic [4:0] out2();
        return {v2, f2, s1_2, s0_2, z2};
    endfunction

    function automatic logic [4:0] out1();
        return {v1, f1, s1_1, s0_1, z1};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [3:0] m, input logic [3:0] cc, input logic [4:0] x);
        vec_t v;
        v.en = e; v.mask = m; v.c = cc; v.exp = x;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_v;

        // Full rotation, c=1010: oZ 0,1,0,1 per 2-cycle slot, frame every 8 cycles
        add(1'b1, 4'b1111, 4'b1010, 5'b11000);
        add(1'b1, 4'b1111, 4'b1010, 5'b10000);
        add(1'b1, 4'b1111, 4'b1010, 5'b10011);
        add(1'b1, 4'b1111, 4'b1010, 5'b10011);
        add(1'b1, 4'b1111, 4'b1010, 5'b10100);
        add(1'b1, 4'b1111, 4'b1010, 5'b10100);
        add(1'b1, 4'b1111, 4'b1010, 5'b10111);
        add(1'b1, 4'b1111, 4'b1010, 5'b10111);
        add(1'b1, 4'b1111, 4'b1010, 5'b11000);
        add(1'b1, 4'b1111, 4'b1010, 5'b10000);
        add(1'b0, 4'b1111, 4'b1010, 5'b00000);
        add(1'b0, 4'b1111, 4'b1010, 5'b00000);
        // Masked channels 1 and 3
        add(1'b1, 4'b1010, 4'b1111, 5'b11011);
        add(1'b1, 4'b1010, 4'b1111, 5'b10011);
        add(1'b1, 4'b1010, 4'b1111, 5'b10111);
        add(1'b1, 4'b1010, 4'b1111, 5'b10111);
        add(1'b1, 4'b1010, 4'b1111, 5'b11011);
        add(1'b1, 4'b1010, 4'b1111, 5'b10011);
        add(1'b1, 4'b0000, 4'b1111, 5'b00000);
        add(1'b1, 4'b0000, 4'b1111, 5'b00000);
        // Mid-slot iC1 toggle, then iMask[2] cleared while channel 2 is active
        add(1'b1, 4'b1111, 4'b0000, 5'b11000);
        add(1'b1, 4'b1111, 4'b0000, 5'b10000);
        add(1'b1, 4'b1111, 4'b0000, 5'b10010);
        add(1'b1, 4'b1111, 4'b0010, 5'b10010);
        add(1'b1, 4'b1111, 4'b0010, 5'b10100);
        add(1'b1, 4'b1011, 4'b0010, 5'b10100);
        add(1'b1, 4'b1011, 4'b1000, 5'b10111);
        add(1'b1, 4'b1011, 4'b0000, 5'b10111);
        add(1'b1, 4'b1011, 4'b0001, 5'b11001);
        // Enable dropped for one cycle, then restart from lowest enabled channel
        add(1'b0, 4'b1011, 4'b0001, 5'b00000);
        add(1'b1, 4'b0110, 4'b0100, 5'b11010);
        add(1'b1, 4'b0110, 4'b0100, 5'b10010);
        add(1'b1, 4'b0110, 4'b0100, 5'b10101);
        add(1'b0, 4'b0110, 4'b0100, 5'b00000);

        rst_n = 1'b0; en = 1'b0; mask = 4'b0000; c = 4'b0000;
        #12;
        check("reset_dut2", out2(), 5'b00000);
        check("reset_dut1", out1(), 5'b00000);
`ifdef TDM_SELECTOR41_PARITY_EN
        check("reset_par", {4'b0000, par2}, 5'b00000);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; mask = tbl[i].mask; c = tbl[i].c;
            sb_q.push_back(tbl[i].exp);
            tick();
            exp_v = sb_q.pop_front();
            check($sformatf("vec%0d", i), out2(), exp_v);
        end

        // SLOT_CYCLES=1 single channel: frame every cycle; two channels: advance every cycle
        en = 1'b1; mask = 4'b0001; c = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("slot1_single%0d", k), out1(), 5'b11001);
        end
        mask = 4'b0011; c = 4'b0010;
        tick(); check("slot1_adv_a", out1(), 5'b10011);
        tick(); check("slot1_adv_b", out1(), 5'b11000);
        tick(); check("slot1_adv_c", out1(), 5'b10011);
        en = 1'b0;
        tick(); check("slot1_stop", out1(), 5'b00000);

        // Asynchronous reset between edges while running
        en = 1'b1; mask = 4'b1111; c = 4'b1111;
        tick(); check("pre_rst_run", out2(), 5'b11001);
        #2; rst_n = 1'b0; #1;
        check("async_rst_dut2", out2(), 5'b00000);
        check("async_rst_dut1", out1(), 5'b00000);
        tick(); check("rst_held", out2(), 5'b00000);
        en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick(); check("rst_release_idle", out2(), 5'b00000);
        en = 1'b1;
        tick(); check("rst_restart", out2(), 5'b11001);
        en = 1'b0;
        tick(); check("rst_restart_stop", out2(), 5'b00000);

`ifdef TDM_SELECTOR41_PARITY_EN
        // Frame parity: c=0111 gives 1 at the second frame pulse, then c=0011 gives 0
        en = 1'b1; mask = 4'b1111; c = 4'b0111;
        for (int k = 1; k <= 17; k++) begin
            if (k == 10) c = 4'b0011;
            tick();
            if (k == 8)  check("par_before", {4'b0000, par2}, 5'b00000);
            if (k == 9)  check("par_frame1", {3'b000, f2, par2}, 5'b00011);
            if (k == 16) check("par_hold",   {4'b0000, par2}, 5'b00001);
            if (k == 17) check("par_frame2", {3'b000, f2, par2}, 5'b00010);
        end
        en = 1'b0;
        tick(); check("par_idle", {4'b0000, par2}, 5'b00000);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
